// File: rtl/ins_cache_r32i.sv
// Direct-mapped read-only instruction cache: ProgAddr in, Instruction out, line refill from memory on miss.
// Latency: hits are combinational (0 cycles); a miss stalls lineWords+1 cycles plus any memory wait cycles.
// Backpressure: InsCacheStall holds the PC while missing; refill beats wait on MemAck with MemReq/MemAddr held stable.
module ins_cache_r32i #(
    parameter int dataW     = 32,
    parameter int lineWords = 4,
    parameter int numLines  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    input  logic             Flush,
    output logic [dataW-1:0] Instruction,
    output logic             InsCacheStall,
    output logic             MemReq,
    output logic [dataW-1:0] MemAddr,
    input  logic             MemAck,
    input  logic [dataW-1:0] MemData
);

    localparam int offW = $clog2(lineWords);
    localparam int idxW = $clog2(numLines);
    localparam int loW  = offW + 2;
    localparam int tagW = dataW - idxW - loW;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t           state;
    logic [numLines-1:0] valid;
    logic [tagW-1:0]  tags [numLines];
    logic [dataW-1:0] lineData [numLines][lineWords];
    logic [offW-1:0]  beat;
    logic             flushPend;
    logic [dataW-1:0] baseAddr;

    logic [offW-1:0]  offset;
    logic [idxW-1:0]  idx;
    logic [tagW-1:0]  tagIn;
    logic [idxW-1:0]  refIdx;
    logic [tagW-1:0]  refTag;
    logic [offW-1:0]  nextBeat;
    logic             beatAck;
    logic             hit;
    logic [1:0]       unusedAddrBits;

    assign offset         = ProgAddr[loW-1:2];
    assign idx            = ProgAddr[loW+idxW-1:loW];
    assign tagIn          = ProgAddr[dataW-1:loW+idxW];
    assign unusedAddrBits = ProgAddr[1:0];

    // The line being refilled is addressed from the latched base, not the live ProgAddr.
    assign refIdx   = baseAddr[loW+idxW-1:loW];
    assign refTag   = baseAddr[dataW-1:loW+idxW];
    assign nextBeat = beat + offW'(1);
    assign beatAck  = (state == REFILL) && MemReq && MemAck;

    // Hit lookup and instruction mux; nothing hits while refilling or held in reset.
    always_comb begin
        hit           = reset && (state == IDLE) && valid[idx] && (tags[idx] == tagIn);
        InsCacheStall = !hit;
        Instruction   = hit ? lineData[idx][offset] : '0;
    end

    // Refill FSM, valid/tag bookkeeping and the registered memory request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            valid     <= '0;
            beat      <= '0;
            flushPend <= 1'b0;
            MemReq    <= 1'b0;
            MemAddr   <= '0;
            baseAddr  <= '0;
            for (int i = 0; i < numLines; i++) tags[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Flush) valid <= '0;
                    if (!hit) begin
                        baseAddr <= {ProgAddr[dataW-1:loW], {loW{1'b0}}};
                        MemAddr  <= {ProgAddr[dataW-1:loW], {loW{1'b0}}};
                        MemReq   <= 1'b1;
                        beat     <= '0;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (Flush) flushPend <= 1'b1;
                    if (beatAck) begin
                        tags[refIdx] <= refTag;
                        // A partially written line must never look valid.
                        if (beat == '0) valid[refIdx] <= 1'b0;
                        if (beat == offW'(lineWords - 1)) begin
                            MemReq    <= 1'b0;
                            beat      <= '0;
                            state     <= IDLE;
                            flushPend <= 1'b0;
                            // A flush seen at any point of the refill, including this edge, discards everything.
                            if (Flush || flushPend) valid <= '0;
                            else                    valid[refIdx] <= 1'b1;
                        end else begin
                            beat    <= nextBeat;
                            MemAddr <= baseAddr + {{(dataW-loW){1'b0}}, nextBeat, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data array write port: one refill word per accepted beat.
    always_ff @(posedge clock) begin
        if (beatAck) lineData[refIdx][beat] <= MemData;
    end

endmodule

// File: tb/tb_ins_cache_r32i.sv
module tb_ins_cache_r32i;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ProgAddr = 32'h0;
    logic        Flush = 1'b0;
    logic [31:0] Instruction;
    logic        InsCacheStall;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [31:0] MemData = 32'h0;

    int tests = 0;
    int fails = 0;
    int ackDelay = 0;
    int waitCnt = 0;

    ins_cache_r32i dut (
        .clock(clock),
        .reset(reset),
        .ProgAddr(ProgAddr),
        .Flush(Flush),
        .Instruction(Instruction),
        .InsCacheStall(InsCacheStall),
        .MemReq(MemReq),
        .MemAddr(MemAddr),
        .MemAck(MemAck),
        .MemData(MemData)
    );

    always #5 clock = ~clock;

    // Memory contents: every word is unique and derived from its address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory responder: acks after ackDelay wait cycles per beat, data follows MemAddr.
    always @(posedge clock) begin
        #2;
        if (!MemReq) begin
            MemAck  = 1'b0;
            waitCnt = 0;
        end else if (waitCnt >= ackDelay) begin
            MemAck  = 1'b1;
            waitCnt = 0;
        end else begin
            MemAck  = 1'b0;
            waitCnt = waitCnt + 1;
        end
        MemData = memWord(MemAddr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an address and count stall cycles until it hits (bounded).
    task automatic fetch(input logic [31:0] a, output int stalls);
        ProgAddr = a;
        #1;
        stalls = 0;
        while (InsCacheStall && stalls < 100) begin
            stalls++;
            @(negedge clock);
            #1;
        end
    endtask

    // Cycle-by-cycle miss with zero-wait memory: 4 beats in order, then a hit.
    task automatic refillCheck(input logic [31:0] base);
        ProgAddr = base;
        #1;
        chk("miss_stall", {31'b0, InsCacheStall}, 32'h1);
        chk("miss_req0", {31'b0, MemReq}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            chk("beat_req", {31'b0, MemReq}, 32'h1);
            chk("beat_addr", MemAddr, base + 32'(4 * i));
            chk("beat_stall", {31'b0, InsCacheStall}, 32'h1);
        end
        @(negedge clock);
        #1;
        chk("fill_hit", {31'b0, InsCacheStall}, 32'h0);
        chk("fill_req_low", {31'b0, MemReq}, 32'h0);
        chk("fill_instr", Instruction, memWord(base));
    endtask

    // Flush raised on refill cycle 'off' (1..4) of a miss; the line must end up invalid.
    task automatic flushAt(input logic [31:0] a, input int off);
        int s;
        ProgAddr = a;
        #1;
        repeat (off) @(negedge clock);
        Flush = 1'b1;
        @(negedge clock);
        Flush = 1'b0;
        repeat (4 - off) @(negedge clock);
        #1;
        chk("flush_req_done", {31'b0, MemReq}, 32'h0);
        chk("flush_line_invalid", {31'b0, InsCacheStall}, 32'h1);
        fetch(a, s);
        chk("flush_refetch_stalls", 32'(s), 32'd5);
        chk("flush_refetch_instr", Instruction, memWord(a));
    endtask

    initial begin
        int s;
        int k;

        // Reset state
        @(negedge clock);
        #1;
        chk("rst_stall", {31'b0, InsCacheStall}, 32'h1);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_req", {31'b0, MemReq}, 32'h0);
        chk("rst_addr", MemAddr, 32'h0);

        // Cold miss at 0x0
        @(negedge clock);
        reset = 1'b1;
        refillCheck(32'h0);

        // Consecutive hits in the filled line
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            fetch(32'(4 * i), s);
            chk("hit_stalls", 32'(s), 32'd0);
            chk("hit_instr", Instruction, memWord(32'(4 * i)));
        end

        // Conflict on index 0
        @(negedge clock);
        fetch(32'h100, s);
        chk("conf_stalls", 32'(s), 32'd5);
        chk("conf_instr", Instruction, memWord(32'h100));
        @(negedge clock);
        fetch(32'h10C, s);
        chk("conf_hit_stalls", 32'(s), 32'd0);
        chk("conf_hit_instr", Instruction, memWord(32'h10C));
        @(negedge clock);
        fetch(32'h0, s);
        chk("conf_refetch_stalls", 32'(s), 32'd5);
        chk("conf_refetch_instr", Instruction, memWord(32'h0));

        // Slow memory: three wait cycles per beat
        @(negedge clock);
        ackDelay = 3;
        ProgAddr = 32'h40;
        #1;
        s = 0;
        k = 0;
        while (InsCacheStall && s < 100) begin
            if (MemReq) begin
                chk("dly_addr", MemAddr, 32'h40 + 32'(4 * (k / 4)));
                k++;
            end
            s++;
            @(negedge clock);
            #1;
        end
        ackDelay = 0;
        chk("dly_stalls", 32'(s), 32'd17);
        chk("dly_instr", Instruction, memWord(32'h40));
        @(negedge clock);
        fetch(32'h4C, s);
        chk("dly_hit_stalls", 32'(s), 32'd0);
        chk("dly_hit_instr", Instruction, memWord(32'h4C));

        // Flush in IDLE invalidates every line
        @(negedge clock);
        ProgAddr = 32'h0;
        Flush = 1'b1;
        #1;
        chk("flush_pre_hit", {31'b0, InsCacheStall}, 32'h0);
        @(negedge clock);
        Flush = 1'b0;
        fetch(32'h0, s);
        chk("flush_idle_stalls", 32'(s), 32'd5);
        @(negedge clock);
        fetch(32'h40, s);
        chk("flush_idle_other", 32'(s), 32'd5);

        // Flush mid-refill and coincident with the last ack
        @(negedge clock);
        flushAt(32'h80, 1);
        @(negedge clock);
        flushAt(32'hC0, 4);

        // Reset during beat 2
        @(negedge clock);
        ProgAddr = 32'h200;
        repeat (3) @(negedge clock);
        #1;
        chk("rbeat_addr", MemAddr, 32'h208);
        reset = 1'b0;
        #1;
        chk("rbeat_req", {31'b0, MemReq}, 32'h0);
        chk("rbeat_stall", {31'b0, InsCacheStall}, 32'h1);
        chk("rbeat_instr", Instruction, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        refillCheck(32'h200);
        @(negedge clock);
        fetch(32'h40, s);
        chk("rbeat_other_invalid", 32'(s), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ins_cache_r32i.md
# ins_cache_r32i

Direct-mapped, read-only instruction cache for the RV32I core, sitting between the program counter and instruction memory. It consumes the PC's program address and returns the instruction word. On a miss it raises the PC's cache-stall input and refills one line from memory over a request/acknowledge handshake. It is the responder to the PC's fetch request.

## Interface
- dataW, 32, address and instruction width (fixed at 32 for RV32I)
- lineWords, 4, 32-bit words per cache line (power of two, ≥2)
- numLines, 16, lines in cache (power of two, ≥2)

- clock  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-low reset
- ProgAddr  in  dataW  fetch address from PC; bits [1:0] ignored
- Flush  in  1  invalidate all lines (e.g. after FENCE.I)
- Instruction  out  dataW  instruction at ProgAddr; valid only when InsCacheStall low
- InsCacheStall  out  1  high while Instruction is not valid; PC holds ProgAddr
- MemReq  out  1  refill beat request
- MemAddr  out  dataW  word-aligned refill beat address
- MemAck  in  1  memory accepted beat; MemData valid this cycle
- MemData  in  dataW  refill word

## Operation
- Address split: offset = ProgAddr[1+log2(lineWords):2], index = next log2(numLines) bits, tag = remaining upper bits. Default: offset [3:2], index [7:4], tag [31:8].
- Storage: per line a valid bit, a tag register and lineWords data words, held in flops/registers with combinational read.
- Hit = valid[index] && tag[index]==tag && state==IDLE && reset high.
- InsCacheStall = !Hit. Instruction = data[index][offset] when Hit, else 0.
- FSM states:
  - IDLE: on a miss, latch the line base (ProgAddr with offset and [1:0] cleared), beat=0, then go to REFILL.
  - REFILL: MemReq=1, MemAddr = base + 4*beat. On MemAck, write MemData into data[index][beat], write tag[index], and beat++.
  - After the ack on beat lineWords-1: set valid[index], clear beat, return to IDLE.
- Handshake: MemReq and MemAddr are registered and stay stable until MemAck. MemAck is ignored while MemReq is low. An ack may arrive in the first REFILL cycle. MemReq stays high between beats, and MemAddr advances in the cycle after each ack.
- valid[index] is cleared on the first refill beat, so a partially filled line never hits.
- Flush in IDLE: clear all valid bits at the next edge.
- Flush during REFILL: set a pending flag. The refill completes normally, then all valid bits are cleared, including the new line, on return to IDLE.
- Flush coincident with the last-beat ack: the flush wins and the line is left invalid.
- ProgAddr changing during REFILL is a PC protocol violation. The refill continues to the latched base; the result is re-evaluated in IDLE.
- Address arithmetic wraps modulo 2^dataW.

## Timing
- Reset (async assert, sync release):
  - all valid=0, state=IDLE, beat=0, flush pending=0, MemReq=0, MemAddr=0
  - InsCacheStall=1, Instruction=0 while reset is low
- Hit latency: 0 cycles. Instruction and InsCacheStall are combinational from ProgAddr and the state registers.
- Miss with zero-wait memory:
  - miss detected in IDLE at cycle N; MemReq high over cycles N+1 to N+lineWords
  - hit at cycle N+lineWords+1
  - InsCacheStall high for lineWords+1 cycles
- Each memory wait cycle adds one stall cycle.
- The PC samples InsCacheStall at the same edge, so it advances exactly at the first hit cycle.
- Reset asserted mid-refill aborts it immediately: MemReq drops asynchronously and all lines are invalid.

## Test plan
- Cold reset, ProgAddr=0x0, MemAck always 1:
  - MemAddr 0x0, 0x4, 0x8, 0xC on successive cycles
  - InsCacheStall high 5 cycles, then Instruction = word written for 0x0
- After that fill, ProgAddr=0x4, 0x8, 0xC on consecutive cycles: hits with zero stall, returning the refill words in order.
- Conflict: fill 0x000, then fetch 0x100 (same index 0, tag 0x01):
  - miss and refill at 0x100..0x10C
  - refetching 0x000 misses again
- MemAck delayed 3 cycles per beat on a miss at 0x40: MemAddr holds each value until its ack; stall lasts 1+4×4=17 cycles.
- Flush:
  - after filling 0x0, Flush for 1 cycle → the next fetch of 0x0 misses
  - Flush asserted mid-refill → the line completes, then is invalid; the refetch misses
- Reset low during beat 2 of a refill:
  - MemReq=0 immediately, stall=1
  - after release, the fetch repeats the full 4-beat refill
